// File: rtl/mag_sort4.sv
// Four-lane L1-magnitude ranking pipeline: capture, metric, then a three-level
// compare-exchange sorting network. One frame per cycle, fixed 4-cycle latency.
module mag_sort4 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  input  logic [WIDTH-1:0] inaReal,
  input  logic [WIDTH-1:0] inaImag,
  input  logic [WIDTH-1:0] inbReal,
  input  logic [WIDTH-1:0] inbImag,
  input  logic [WIDTH-1:0] incReal,
  input  logic [WIDTH-1:0] incImag,
  input  logic [WIDTH-1:0] indReal,
  input  logic [WIDTH-1:0] indImag,
  output logic             outValid,
  output logic [1:0]       outIdx0,
  output logic [1:0]       outIdx1,
  output logic [1:0]       outIdx2,
  output logic [1:0]       outIdx3,
  output logic [WIDTH:0]   outMag0,
  output logic [WIDTH:0]   outMag1,
  output logic [WIDTH:0]   outMag2,
  output logic [WIDTH:0]   outMag3
);

  // Handshake: inValid qualifies one frame on the edge it is sampled; there is
  // no ready, every qualified frame is accepted, and outValid is a one-cycle
  // pulse per ranked frame that the consumer must take (no backpressure).

  typedef logic [WIDTH:0]   magT;
  typedef logic [1:0]       idxT;
  typedef logic [WIDTH-1:0] compT;

  function automatic compT absVal(input compT v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  // Sort key (mag, idx): larger magnitude wins, lower lane index breaks ties.
  function automatic logic outranks(input magT mx, input idxT ix,
                                    input magT my, input idxT iy);
    return (mx > my) || ((mx == my) && (ix < iy));
  endfunction

  // ---------------------------------------------------------------------------
  // Capture stage: raw lane components
  // ---------------------------------------------------------------------------
  compT inRe [4];
  compT inIm [4];

  assign inRe[0] = inaReal;
  assign inIm[0] = inaImag;
  assign inRe[1] = inbReal;
  assign inIm[1] = inbImag;
  assign inRe[2] = incReal;
  assign inIm[2] = incImag;
  assign inRe[3] = indReal;
  assign inIm[3] = indImag;

  logic capValid;
  compT capRe [4];
  compT capIm [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      capValid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        capRe[i] <= '0;
        capIm[i] <= '0;
      end
    end else begin
      capValid <= inValid;
      if (inValid) begin
        for (int i = 0; i < 4; i++) begin
          capRe[i] <= inRe[i];
          capIm[i] <= inIm[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S0: metric per lane, tagged with its lane index
  // ---------------------------------------------------------------------------
  magT metric [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      metric[i] = magT'(absVal(capRe[i])) + magT'(absVal(capIm[i]));
    end
  end

  logic s0Valid;
  magT  s0Mag [4];
  idxT  s0Idx [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0Valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        s0Mag[i] <= '0;
        s0Idx[i] <= '0;
      end
    end else begin
      s0Valid <= capValid;
      if (capValid) begin
        for (int i = 0; i < 4; i++) begin
          s0Mag[i] <= metric[i];
          s0Idx[i] <= idxT'(i);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1: compare-exchange (0,1) and (2,3)
  // ---------------------------------------------------------------------------
  magT s1MagNext [4];
  idxT s1IdxNext [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s1MagNext[i] = s0Mag[i];
      s1IdxNext[i] = s0Idx[i];
    end
    if (outranks(s0Mag[1], s0Idx[1], s0Mag[0], s0Idx[0])) begin
      s1MagNext[0] = s0Mag[1];
      s1IdxNext[0] = s0Idx[1];
      s1MagNext[1] = s0Mag[0];
      s1IdxNext[1] = s0Idx[0];
    end
    if (outranks(s0Mag[3], s0Idx[3], s0Mag[2], s0Idx[2])) begin
      s1MagNext[2] = s0Mag[3];
      s1IdxNext[2] = s0Idx[3];
      s1MagNext[3] = s0Mag[2];
      s1IdxNext[3] = s0Idx[2];
    end
  end

  logic s1Valid;
  magT  s1Mag [4];
  idxT  s1Idx [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        s1Mag[i] <= '0;
        s1Idx[i] <= '0;
      end
    end else begin
      s1Valid <= s0Valid;
      if (s0Valid) begin
        for (int i = 0; i < 4; i++) begin
          s1Mag[i] <= s1MagNext[i];
          s1Idx[i] <= s1IdxNext[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: compare-exchange (0,2) and (1,3); afterwards 0 is max and 3 is min
  // ---------------------------------------------------------------------------
  magT s2MagNext [4];
  idxT s2IdxNext [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s2MagNext[i] = s1Mag[i];
      s2IdxNext[i] = s1Idx[i];
    end
    if (outranks(s1Mag[2], s1Idx[2], s1Mag[0], s1Idx[0])) begin
      s2MagNext[0] = s1Mag[2];
      s2IdxNext[0] = s1Idx[2];
      s2MagNext[2] = s1Mag[0];
      s2IdxNext[2] = s1Idx[0];
    end
    if (outranks(s1Mag[3], s1Idx[3], s1Mag[1], s1Idx[1])) begin
      s2MagNext[1] = s1Mag[3];
      s2IdxNext[1] = s1Idx[3];
      s2MagNext[3] = s1Mag[1];
      s2IdxNext[3] = s1Idx[1];
    end
  end

  logic s2Valid;
  magT  s2Mag [4];
  idxT  s2Idx [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        s2Mag[i] <= '0;
        s2Idx[i] <= '0;
      end
    end else begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        for (int i = 0; i < 4; i++) begin
          s2Mag[i] <= s2MagNext[i];
          s2Idx[i] <= s2IdxNext[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: compare-exchange (1,2); these registers are the outputs
  // ---------------------------------------------------------------------------
  magT s3MagNext [4];
  idxT s3IdxNext [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s3MagNext[i] = s2Mag[i];
      s3IdxNext[i] = s2Idx[i];
    end
    if (outranks(s2Mag[2], s2Idx[2], s2Mag[1], s2Idx[1])) begin
      s3MagNext[1] = s2Mag[2];
      s3IdxNext[1] = s2Idx[2];
      s3MagNext[2] = s2Mag[1];
      s3IdxNext[2] = s2Idx[1];
    end
  end

  logic s3Valid;
  magT  s3Mag [4];
  idxT  s3Idx [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3Valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        s3Mag[i] <= '0;
        s3Idx[i] <= '0;
      end
    end else begin
      s3Valid <= s2Valid;
      if (s2Valid) begin
        for (int i = 0; i < 4; i++) begin
          s3Mag[i] <= s3MagNext[i];
          s3Idx[i] <= s3IdxNext[i];
        end
      end
    end
  end

  assign outValid = s3Valid;
  assign outIdx0  = s3Idx[0];
  assign outIdx1  = s3Idx[1];
  assign outIdx2  = s3Idx[2];
  assign outIdx3  = s3Idx[3];
  assign outMag0  = s3Mag[0];
  assign outMag1  = s3Mag[1];
  assign outMag2  = s3Mag[2];
  assign outMag3  = s3Mag[3];

endmodule

// File: tb/tb_mag_sort4.sv
// Scoreboard bench for mag_sort4: directed frames, streaming, resets and random
// frames checked against a selection-sort reference model.
module tb_mag_sort4;

  localparam int WIDTH = 16;
  localparam int MW    = WIDTH + 1;
  localparam int EW    = 4 * 2 + 4 * MW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  logic             inValid = 1'b0;
  logic [WIDTH-1:0] inaReal = '0, inaImag = '0, inbReal = '0, inbImag = '0;
  logic [WIDTH-1:0] incReal = '0, incImag = '0, indReal = '0, indImag = '0;
  logic             outValid;
  logic [1:0]       outIdx0, outIdx1, outIdx2, outIdx3;
  logic [MW-1:0]    outMag0, outMag1, outMag2, outMag3;

  mag_sort4 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .inValid(inValid),
    .inaReal(inaReal), .inaImag(inaImag), .inbReal(inbReal), .inbImag(inbImag),
    .incReal(incReal), .incImag(incImag), .indReal(indReal), .indImag(indImag),
    .outValid(outValid),
    .outIdx0(outIdx0), .outIdx1(outIdx1), .outIdx2(outIdx2), .outIdx3(outIdx3),
    .outMag0(outMag0), .outMag1(outMag1), .outMag2(outMag2), .outMag3(outMag3)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            issue_q[$];
  int            tests_run = 0;
  int            tests_failed = 0;

  function automatic logic [EW-1:0] pack_out();
    return {outMag3, outMag2, outMag1, outMag0, outIdx3, outIdx2, outIdx1, outIdx0};
  endfunction

  function automatic logic [EW-1:0] mk(input int i0, i1, i2, i3, m0, m1, m2, m3);
    return {MW'(m3), MW'(m2), MW'(m1), MW'(m0), 2'(i3), 2'(i2), 2'(i1), 2'(i0)};
  endfunction

  // Reference: L1 magnitude with plain integers, then pick the best remaining
  // lane per rank (strict > over ascending index keeps the lowest index on ties).
  function automatic logic [EW-1:0] ref_rank(input int re[4], input int im[4]);
    int m[4];
    bit used[4];
    logic [EW-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      m[i] = (re[i] < 0 ? -re[i] : re[i]) + (im[i] < 0 ? -im[i] : im[i]);
      used[i] = 1'b0;
    end
    for (int rank = 0; rank < 4; rank++) begin
      int best;
      best = -1;
      for (int i = 0; i < 4; i++)
        if (!used[i] && (best < 0 || m[i] > m[best])) best = i;
      used[best] = 1'b1;
      r[rank*2 +: 2]       = 2'(best);
      r[8 + rank*MW +: MW] = MW'(m[best]);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] mon_exp;
  int            mon_issue;
  always @(negedge clk) begin
    if (!rst && outValid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_outValid: got outValid=1 expected 0 (cycle %0d)", cycleCnt);
      end else begin
        mon_exp   = exp_q.pop_front();
        mon_issue = issue_q.pop_front();
        check("frame_data", pack_out(), mon_exp);
        check_int("frame_latency", cycleCnt - mon_issue, 4);
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_frame(input int ar, ai, br, bi, cr, ci, dr, di);
    int re[4];
    int im[4];
    re = '{ar, br, cr, dr};
    im = '{ai, bi, ci, di};
    inaReal = 16'(ar); inaImag = 16'(ai);
    inbReal = 16'(br); inbImag = 16'(bi);
    incReal = 16'(cr); incImag = 16'(ci);
    indReal = 16'(dr); indImag = 16'(di);
    inValid = 1'b1;
    exp_q.push_back(ref_rank(re, im));
    issue_q.push_back(cycleCnt + 1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_int("drain_timeout", exp_q.size(), 0);
  endtask

  // Asserts rst between edges, flushes the scoreboard and checks the outputs
  // cleared without waiting for a clock.
  task automatic async_reset(input int hold_cycles, input bit drive_during);
    #2;
    rst = 1'b1;
    exp_q.delete();
    issue_q.delete();
    #1;
    check("reset_outputs_immediate", pack_out(), '0);
    check_int("reset_outValid_immediate", int'(outValid), 0);
    if (drive_during) begin
      inaReal = 16'd100;
      inValid = 1'b1;
    end
    repeat (hold_cycles) @(posedge clk);
    #1;
    inValid = 1'b0;
    rst = 1'b0;
  endtask

  function automatic int rnd_val(input int mode);
    int pick;
    case (mode)
      0:       return int'($urandom_range(0, 65535)) - 32768;
      1:       return int'($urandom_range(0, 6)) - 3;
      default: begin
        pick = int'($urandom_range(0, 3));
        return (pick == 0) ? -32768 : (pick == 1) ? 32767 : (pick == 2) ? 0 : -1;
      end
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    int mode;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_state", pack_out(), '0);
    check_int("reset_outValid", int'(outValid), 0);
    idle(1);

    // distinct values, then hold
    send_frame(3, 4, -10, 0, 1, 1, 0, -5);
    drain();
    idle(5);
    check("hold_distinct", pack_out(), mk(1, 0, 3, 2, 10, 7, 5, 2));

    // full and partial ties
    send_frame(2, -2, 2, -2, 2, -2, 2, -2);
    drain();
    check("ties_all", pack_out(), mk(0, 1, 2, 3, 4, 4, 4, 4));
    send_frame(5, 0, 1, 1, 0, 5, 9, 0);
    drain();
    check("ties_partial", pack_out(), mk(3, 0, 2, 1, 9, 5, 5, 2));

    // extremes
    send_frame(-32768, -32768, 32767, 32767, 0, 0, -32768, 0);
    drain();
    check("extremes", pack_out(), mk(0, 1, 3, 2, 65536, 65534, 32768, 0));
    idle(2);

    // streaming, back to back
    send_frame(3, 4, -10, 0, 1, 1, 0, -5);
    send_frame(2, -2, 2, -2, 2, -2, 2, -2);
    send_frame(-32768, -32768, 32767, 32767, 0, 0, -32768, 0);
    drain();
    idle(3);
    check("stream_hold", pack_out(), mk(0, 1, 3, 2, 65536, 65534, 32768, 0));

    // async reset mid-cycle, inValid asserted under reset is ignored
    async_reset(2, 1'b1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (outValid) seen++;
    end
    check_int("post_reset_quiet", seen, 0);
    @(posedge clk);
    #1;

    // reset mid-flight
    send_frame(3, 4, -10, 0, 1, 1, 0, -5);
    @(posedge clk);
    async_reset(1, 1'b0);
    idle(6);
    check("midflight_outputs_zero", pack_out(), '0);
    send_frame(5, 0, 1, 1, 0, 5, 9, 0);
    drain();
    check("midflight_new_frame", pack_out(), mk(3, 0, 2, 1, 9, 5, 5, 2));

    // randomized frames with bubbles
    for (int it = 0; it < 300; it++) begin
      if (it == 150) async_reset(1, 1'b0);
      if ($urandom_range(0, 9) < 7) begin
        mode = int'($urandom_range(0, 2));
        send_frame(rnd_val(mode), rnd_val(mode), rnd_val(mode), rnd_val(mode),
                   rnd_val(mode), rnd_val(mode), rnd_val(mode), rnd_val(mode));
      end else begin
        idle(1);
      end
    end
    drain();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
